// File: rtl/decode_queue.sv
// decode_queue: elastic FIFO between instruction decode and the dispatcher
package decode_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
  } decode_result_t;
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  decode_result_t           in_decode_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output decode_result_t           out_decode_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  decode_result_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic push, pop;
  // in_ready looks only at registered occupancy so out_ready never reaches decode combinationally
  assign in_ready_o   = count_q != FULL;
  assign out_valid_o  = count_q != '0;
  assign out_decode_o = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;
  // next-state: flush empties the queue and overrides any push or pop
  always_comb begin
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush_i ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // pointer and occupancy registers; reset behaves like a flush
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage array is never cleared; only accepted entries are written
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= in_decode_i;
  end
endmodule
